// File: rtl/ov7670_pattern_tx.sv
// ov7670_pattern_tx: DVP test-pattern source emitting frames in ov7670_capture format
// (vsync pulse, back porch, active lines of RGB444 byte pairs, front porch).
// Patterns: 0 colour bars, 1 ramp, 2 checkerboard, 3 solid colour.
// Optional build macro OV7670_PATTERN_TX_FRAME_CNT_EN stamps an 8-bit frame count
// into pixel (0,0) of every frame.
module ov7670_pattern_tx #(
  parameter int unsigned H_PIXELS    = 320,
  parameter int unsigned V_LINES     = 240,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy
);

  localparam int unsigned LineLen  = 2 * H_PIXELS + H_BLANK;
  localparam int unsigned ActBytes = 2 * H_PIXELS;
  localparam int unsigned CW       = $clog2(LineLen);
  localparam int unsigned Max1     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned Max2     = (V_LINES > V_FRONT) ? V_LINES : V_FRONT;
  localparam int unsigned MaxLines = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned LW       = (MaxLines > 1) ? $clog2(MaxLines) : 1;
  localparam int unsigned BarW     = H_PIXELS / 8;
  localparam int unsigned BCW      = (BarW > 1) ? $clog2(BarW) : 1;

  localparam logic [CW-1:0]  ColLast    = CW'(LineLen - 1);
  localparam logic [CW-1:0]  ColAct     = CW'(ActBytes);
  localparam logic [LW-1:0]  VsyncLast  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0]  VbackLast  = LW'(V_BACK - 1);
  localparam logic [LW-1:0]  ActiveLast = LW'(V_LINES - 1);
  localparam logic [LW-1:0]  VfrontLast = LW'(V_FRONT - 1);
  localparam logic [BCW-1:0] BarLast    = BCW'(BarW - 1);

  typedef enum logic [2:0] {StIdle, StVsync, StVback, StActive, StVfront} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [LW-1:0]  line_q, line_d;
  logic [LW-1:0]  line_lim;
  logic [BCW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]     bar_q, bar_d;
  logic [1:0]     pat_q;
  logic [11:0]    solid_q;
  logic           href_d;
  logic [3:0]     x_hi;
  logic           y4;
  logic [11:0]    pat_rgb;
  logic [11:0]    rgb;
  logic [7:0]     data_d;
  logic           frame_done_d;

  assign busy = (state_q != StIdle);

  // Frame sequencer: byte-column and line counters drive the state walk.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    unique case (state_q)
      StVsync:  line_lim = VsyncLast;
      StVback:  line_lim = VbackLast;
      StActive: line_lim = ActiveLast;
      StVfront: line_lim = VfrontLast;
      default:  line_lim = '0;
    endcase
    if (state_q == StIdle) begin
      col_d  = '0;
      line_d = '0;
      if (enable) state_d = StVsync;
    end else if (col_q != ColLast) begin
      col_d = col_q + CW'(1);
    end else begin
      col_d = '0;
      if (line_q != line_lim) begin
        line_d = line_q + LW'(1);
      end else begin
        line_d = '0;
        unique case (state_q)
          StVsync:  state_d = StVback;
          StVback:  state_d = StActive;
          StActive: state_d = StVfront;
          StVfront: state_d = enable ? StVsync : StIdle;
          default:  state_d = StIdle;
        endcase
      end
    end
  end

  // Pixel datapath, evaluated for the position the next cycle will present.
  always_comb begin
    href_d    = (state_d == StActive) && (col_d < ColAct);
    bar_cnt_d = bar_cnt_q;
    bar_d     = bar_q;
    if (col_d == '0) begin
      bar_cnt_d = '0;
      bar_d     = '0;
    end else if (href_d && !col_d[0]) begin
      // Even byte starts a new pixel; step the bar without dividing x.
      if (bar_cnt_q == BarLast) begin
        bar_cnt_d = '0;
        bar_d     = bar_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BCW'(1);
      end
    end
    x_hi = 4'(col_d >> 3);  // x[5:2], since x = col >> 1
    y4   = 1'(line_d >> 4);
    unique case (pat_q)
      2'd0:    pat_rgb = {{4{bar_d[2]}}, {4{bar_d[1]}}, {4{bar_d[0]}}};
      2'd1:    pat_rgb = {x_hi, x_hi, x_hi};
      2'd2:    pat_rgb = (x_hi[2] ^ y4) ? 12'hFFF : 12'h000;
      default: pat_rgb = solid_q;
    endcase
    if (!href_d)      data_d = 8'h00;
    else if (!col_d[0]) data_d = {4'h0, rgb[11:8]};
    else              data_d = rgb[7:0];
    frame_done_d = (state_d == StVfront) && (col_d == ColLast) && (line_d == VfrontLast);
  end

`ifdef OV7670_PATTERN_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;
  logic       first_pix;

  // Frame counter, advanced once per completed frame.
  always_ff @(posedge clk) begin
    if (reset)           frame_cnt_q <= 8'd0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign first_pix = (state_d == StActive) && (line_d == '0) && (col_d < CW'(2));
  assign rgb       = first_pix ? {frame_cnt_q, 4'h0} : pat_rgb;
`else
  assign rgb = pat_rgb;
`endif

  // State, counters, pattern latch and registered DVP outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      col_q      <= '0;
      line_q     <= '0;
      bar_cnt_q  <= '0;
      bar_q      <= '0;
      pat_q      <= '0;
      solid_q    <= '0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      bar_cnt_q  <= bar_cnt_d;
      bar_q      <= bar_d;
      vsync      <= (state_d == StVsync);
      href       <= href_d;
      data       <= data_d;
      frame_done <= frame_done_d;
      // Pattern choice is frozen per frame.
      if (state_d == StVsync && state_q != StVsync) begin
        pat_q   <= pattern_sel;
        solid_q <= solid_rgb;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pattern_tx.sv
// Bench for ov7670_pattern_tx with an 8x4 frame, 4-byte blanking and one-line porches
// (line = 20 clocks, frame = 140 clocks). Clock k = k-th cycle after enable is sampled.
module tb_ov7670_pattern_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic        vsync, href, frame_done, busy;
  logic [7:0]  data;

  ov7670_pattern_tx #(
    .H_PIXELS(8), .V_LINES(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .vsync(vsync), .href(href), .data(data),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       hv [0:511];
  logic       vv [0:511];
  logic       fv [0:511];
  logic       bv [0:511];
  logic [7:0] dv [0:511];
  logic [7:0] bytes [0:255];
  int nb, nfd, nvr, npulse, nblank;
  int fd_clk [0:7];
  int vr_clk [0:7];

  typedef struct {
    logic [1:0]  pat;
    logic [11:0] solid;
    int          x;
    int          y;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs [0:12];
  logic [7:0] exp_line [0:15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Starts in IDLE at a falling edge; samples clocks 1..ncyc.
  task automatic capture(input logic [1:0] p0, input logic [11:0] s, input int ncyc,
                         input int drop_at, input int chg_at, input logic [1:0] p1,
                         input int rst_at);
    logic ph, pv;
    ph = 1'b0; pv = 1'b0;
    nb = 0; nfd = 0; nvr = 0; npulse = 0; nblank = 0;
    pattern_sel = p0;
    solid_rgb   = s;
    enable      = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      hv[k] = href; vv[k] = vsync; fv[k] = frame_done; bv[k] = busy; dv[k] = data;
      if (href) begin
        if (nb < 256) bytes[nb] = data;
        nb++;
      end
      if (href && !ph) npulse++;
      if (vsync && !pv) begin
        if (nvr < 8) vr_clk[nvr] = k;
        nvr++;
      end
      ph = href; pv = vsync;
      if (!href && data != 8'h00) nblank++;
      if (frame_done) begin
        if (nfd < 8) fd_clk[nfd] = k;
        nfd++;
      end
      if (k >= drop_at) enable = 1'b0;
      if (k == chg_at) pattern_sel = p1;
      if (k == rst_at) reset = 1'b1;
    end
    do_reset();
  endtask

  initial begin
    int bad;
    exp_line = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hFF,
                 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'hF0, 8'h0F, 8'hFF};
    vecs[0]  = '{2'd0, 12'h000, 1, 1, 8'h00, 8'h0F};
    vecs[1]  = '{2'd0, 12'h000, 2, 2, 8'h00, 8'hF0};
    vecs[2]  = '{2'd0, 12'h000, 3, 3, 8'h00, 8'hFF};
    vecs[3]  = '{2'd0, 12'h000, 4, 1, 8'h0F, 8'h00};
    vecs[4]  = '{2'd0, 12'h000, 5, 2, 8'h0F, 8'h0F};
    vecs[5]  = '{2'd0, 12'h000, 6, 3, 8'h0F, 8'hF0};
    vecs[6]  = '{2'd1, 12'h000, 4, 0, 8'h01, 8'h11};
    vecs[7]  = '{2'd1, 12'h000, 3, 2, 8'h00, 8'h00};
    vecs[8]  = '{2'd1, 12'h000, 7, 3, 8'h01, 8'h11};
    vecs[9]  = '{2'd2, 12'hFFF, 5, 3, 8'h00, 8'h00};
    vecs[10] = '{2'd3, 12'hA5C, 2, 1, 8'h0A, 8'h5C};
    vecs[11] = '{2'd3, 12'h123, 0, 3, 8'h01, 8'h23};
    vecs[12] = '{2'd3, 12'h7E1, 7, 2, 8'h07, 8'hE1};

    // Reset state, and reset wins over enable.
    reset = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vsync", vsync, 0);
    chk("rst_href", href, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    do_reset();

    // Single-frame colour bars.
    capture(2'd0, 12'h000, 150, 1, 0, 2'd0, 0);
    chk("bars_vsync_rise", vr_clk[0], 1);
    chk("bars_vsync_20", vv[20], 1);
    chk("bars_vsync_21", vv[21], 0);
    chk("bars_vsync_count", nvr, 1);
    chk("bars_href_40", hv[40], 0);
    chk("bars_href_41", hv[41], 1);
    chk("bars_href_56", hv[56], 1);
    chk("bars_href_57", hv[57], 0);
    chk("bars_href_pulses", npulse, 4);
    chk("bars_bytes", nb, 64);
    chk("bars_blank_data", nblank, 0);
    chk("bars_fd_count", nfd, 1);
    chk("bars_fd_clk", fd_clk[0], 140);
    chk("bars_busy_140", bv[140], 1);
    chk("bars_busy_141", bv[141], 0);
    for (int i = 2; i < 16; i++) chk($sformatf("bars_line0_byte%0d", i), bytes[i], exp_line[i]);

    // Continuous frames with enable held, released in frame 3.
    capture(2'd0, 12'h000, 430, 380, 0, 2'd0, 0);
    chk("cont_fd_count", nfd, 3);
    chk("cont_fd0", fd_clk[0], 140);
    chk("cont_fd1", fd_clk[1], 280);
    chk("cont_fd2", fd_clk[2], 420);
    chk("cont_vsync_count", nvr, 3);
    chk("cont_vsync1", vr_clk[1], 141);
    chk("cont_vsync2", vr_clk[2], 281);
    chk("cont_busy_421", bv[421], 0);

    // Solid colour.
    capture(2'd3, 12'hA5C, 150, 1, 0, 2'd0, 0);
    chk("solid_bytes", nb, 64);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
`ifdef OV7670_PATTERN_TX_FRAME_CNT_EN
      if (i != 0)
`endif
      if (bytes[2*i] != 8'h0A || bytes[2*i+1] != 8'h5C) bad++;
    end
    chk("solid_bad_pairs", bad, 0);

    // Pattern change mid-frame applies next frame only.
    capture(2'd2, 12'h000, 290, 150, 60, 2'd1, 0);
    chk("chg_fd_count", nfd, 2);
    bad = 0;
    for (int i = 0; i < 64; i++) if (bytes[i] != 8'h00) bad++;
    chk("chg_frame1_checker", bad, 0);
    chk("chg_f2_x4_b0", bytes[72], 8'h01);
    chk("chg_f2_x4_b1", bytes[73], 8'h11);
    chk("chg_f2_x1_b1", bytes[67], 8'h00);
    chk("chg_f2_x7y3_b0", bytes[126], 8'h01);
    chk("chg_f2_x7y3_b1", bytes[127], 8'h11);

    // Enable dropped during active line 1.
    capture(2'd0, 12'h000, 200, 65, 0, 2'd0, 0);
    chk("drop_href_pulses", npulse, 4);
    chk("drop_fd_count", nfd, 1);
    chk("drop_fd_clk", fd_clk[0], 140);
    chk("drop_busy_140", bv[140], 1);
    chk("drop_busy_141", bv[141], 0);
    chk("drop_vsync_count", nvr, 1);

    // Reset mid-frame aborts.
    capture(2'd0, 12'h000, 200, 1, 0, 2'd0, 50);
    chk("abort_href_50", hv[50], 1);
    chk("abort_href_51", hv[51], 0);
    chk("abort_data_51", dv[51], 0);
    chk("abort_busy_51", bv[51], 0);
    chk("abort_vsync_51", vv[51], 0);
    chk("abort_fd_count", nfd, 0);

`ifdef OV7670_PATTERN_TX_FRAME_CNT_EN
    capture(2'd3, 12'hA5C, 430, 380, 0, 2'd0, 0);
    chk("fcnt_f1_b0", bytes[0], 8'h00);
    chk("fcnt_f1_b1", bytes[1], 8'h00);
    chk("fcnt_f2_b1", bytes[65], 8'h10);
    chk("fcnt_f3_b0", bytes[128], 8'h00);
    chk("fcnt_f3_b1", bytes[129], 8'h20);
    chk("fcnt_f3_x1", bytes[131], 8'h5C);
`endif

    // Table of single-pixel vectors.
    for (int v = 0; v < 13; v++) begin
      int idx;
      capture(vecs[v].pat, vecs[v].solid, 145, 1, 0, 2'd0, 0);
      idx = vecs[v].y * 16 + 2 * vecs[v].x;
      chk($sformatf("vec%0d_b0", v), bytes[idx], vecs[v].b0);
      chk($sformatf("vec%0d_b1", v), bytes[idx+1], vecs[v].b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
